sigmoid_pwl_pipe: RTL and testbench

Pipelined piecewise-linear (PLAN-style) sigmoid evaluator for the VAE activation path. It takes a signed fixed-point x, evaluates the positive-half curve on |x| using shift-only slopes, then applies the symmetry sigmoid(-x) = 1 - sigmoid(|x|) for negative inputs. It feeds the negation/offset stage of the activation path with a valid/ready stream and accepts one sample per cycle.

---
 rtl/sigmoid_pwl_pipe.sv | 147 ++++++++++++++
 tb/tb_sigmoid_pwl_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_pwl_pipe.sv
// sigmoid_pwl_pipe: three-stage piecewise-linear (PLAN) sigmoid evaluator.
// Stage 1 folds x to |x| and picks a segment, stage 2 evaluates the
// shift-only line for that segment, stage 3 mirrors the result for x<0.
// Optional macro SIGMOID_SAT_COUNT_EN adds sat_clr/sat_cnt, which count
// accepted inputs landing in the flat (|x| >= 5.0) segment.
module sigmoid_pwl_pipe #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [DATA_W-1:0] y_out
`ifdef SIGMOID_SAT_COUNT_EN
    ,
    input  logic                     sat_clr,
    output logic        [15:0]       sat_cnt
`endif
);

    localparam int                ONE_I   = 1 << FRAC_BITS;
    localparam logic [DATA_W-1:0] ONE     = DATA_W'(ONE_I);
    localparam logic [DATA_W-1:0] BP1     = DATA_W'(ONE_I);
    localparam logic [DATA_W-1:0] BP2     = DATA_W'((19 * ONE_I) >> 3);
    localparam logic [DATA_W-1:0] BP3     = DATA_W'(5 * ONE_I);
    localparam logic [DATA_W-1:0] OFF0    = DATA_W'(ONE_I >> 1);
    localparam logic [DATA_W-1:0] OFF1    = DATA_W'((5 * ONE_I) >> 3);
    localparam logic [DATA_W-1:0] OFF2    = DATA_W'((27 * ONE_I) >> 5);
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

    // Magnitude with saturation: the most negative code negates to itself,
    // so it is clamped to the largest positive code instead.
    function automatic logic [DATA_W-1:0] abs_sat(input logic signed [DATA_W-1:0] x);
        logic signed [DATA_W-1:0] m;
        if (x[DATA_W-1] == 1'b0) begin
            return $unsigned(x);
        end
        m = -x;
        if (m[DATA_W-1]) begin
            return MAX_POS;
        end
        return $unsigned(m);
    endfunction

    // Segment index; a value equal to a breakpoint belongs to the upper segment.
    function automatic logic [1:0] seg_of(input logic [DATA_W-1:0] a);
        if (a < BP1)      return 2'd0;
        else if (a < BP2) return 2'd1;
        else if (a < BP3) return 2'd2;
        else              return 2'd3;
    endfunction

    // Positive-half curve; every segment tops out at or below ONE.
    function automatic logic [DATA_W-1:0] pwl_eval(input logic [DATA_W-1:0] a,
                                                   input logic [1:0]        seg);
        case (seg)
            2'd0:    return (a >> 2) + OFF0;
            2'd1:    return (a >> 3) + OFF1;
            2'd2:    return (a >> 5) + OFF2;
            default: return ONE;
        endcase
    endfunction

    // Symmetry sigmoid(-x) = 1 - sigmoid(|x|); p <= ONE so no wrap occurs.
    function automatic logic [DATA_W-1:0] apply_sym(input logic [DATA_W-1:0] p,
                                                    input logic              neg);
        return neg ? (ONE - p) : p;
    endfunction

    logic              adv;
    logic [DATA_W-1:0] abs_in;
    logic [1:0]        seg_in;

    logic              vld_p0, neg_p0;
    logic [DATA_W-1:0] abs_p0;
    logic [1:0]        seg_p0;

    logic              vld_p1, neg_p1;
    logic [DATA_W-1:0] pwl_p1;

    logic              vld_p2;
    logic [DATA_W-1:0] y_p2;

    assign adv       = !vld_p2 || out_ready;
    assign in_ready  = adv;
    assign abs_in    = abs_sat(x_in);
    assign seg_in    = seg_of(abs_in);
    assign out_valid = vld_p2;
    assign y_out     = y_p2;

    // Stage 1: capture sign, magnitude and segment of the incoming sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            neg_p0 <= 1'b0;
            abs_p0 <= '0;
            seg_p0 <= 2'd0;
        end else if (adv) begin
            vld_p0 <= in_valid;
            neg_p0 <= x_in[DATA_W-1];
            abs_p0 <= abs_in;
            seg_p0 <= seg_in;
        end
    end

    // Stage 2: evaluate the shift-only line of the chosen segment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            neg_p1 <= 1'b0;
            pwl_p1 <= '0;
        end else if (adv) begin
            vld_p1 <= vld_p0;
            neg_p1 <= neg_p0;
            pwl_p1 <= pwl_eval(abs_p0, seg_p0);
        end
    end

    // Stage 3: mirror negative inputs and present the result downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            y_p2   <= '0;
        end else if (adv) begin
            vld_p2 <= vld_p1;
            y_p2   <= apply_sym(pwl_p1, neg_p1);
        end
    end

`ifdef SIGMOID_SAT_COUNT_EN
    // Saturating count of accepted flat-segment inputs; clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt <= 16'd0;
        end else if (sat_clr) begin
            sat_cnt <= 16'd0;
        end else if (in_valid && adv && (seg_in == 2'd3) && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sigmoid_pwl_pipe.sv
// Scoreboard bench for sigmoid_pwl_pipe: accepted inputs push an expected
// value (directed constant or reference model), a negedge monitor pops and
// compares every transferred output, including its cycle of arrival.
`timescale 1ns/1ps
module tb_sigmoid_pwl_pipe;
    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int ONE       = 1 << FRAC_BITS;

    logic                     clk       = 1'b0;
    logic                     rst_n     = 1'b0;
    logic                     in_valid  = 1'b0;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x_in      = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic        [DATA_W-1:0] y_out;
`ifdef SIGMOID_SAT_COUNT_EN
    logic                     sat_clr   = 1'b0;
    logic        [15:0]       sat_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int stamp_q[$];
    int stall_q[$];
    int cyc     = 0;
    int stalls  = 0;
    int dir_exp = -1;

    always #5 clk = ~clk;

    sigmoid_pwl_pipe #(.DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out)
`ifdef SIGMOID_SAT_COUNT_EN
        ,
        .sat_clr   (sat_clr),
        .sat_cnt   (sat_cnt)
`endif
    );

    // Reference: sigmoid approximation from the breakpoint table in real units
    function automatic int model(input int x);
        int  a, p;
        real r;
        a = (x < 0) ? -x : x;
        if (a > (1 << (DATA_W - 1)) - 1) a = (1 << (DATA_W - 1)) - 1;
        r = real'(a) / real'(ONE);
        if (r < 1.0)        p = a / 4  + ONE / 2;
        else if (r < 2.375) p = a / 8  + (5 * ONE) / 8;
        else if (r < 5.0)   p = a / 32 + (27 * ONE) / 32;
        else                p = ONE;
        return (x < 0) ? ONE - p : p;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: handshake rule, in-order data and arrival cycle of each output
    always @(negedge clk) begin
        int e, st, sl;
        if (rst_n) begin
            cyc++;
            check("in_ready_rule", int'(in_ready), int'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got y=%0d required no output", y_out);
                end else begin
                    e  = exp_q.pop_front();
                    st = stamp_q.pop_front();
                    sl = stall_q.pop_front();
                    check("y_out", int'(y_out), e);
                    check("latency_cycle", cyc, st + 3 + (stalls - sl));
                end
            end
            if (out_valid && !out_ready) stalls++;
            if (in_valid && in_ready) begin
                exp_q.push_back((dir_exp >= 0) ? dir_exp : model(int'(x_in)));
                stamp_q.push_back(cyc);
                stall_q.push_back(stalls);
            end
        end
    end

    // Present one sample (called at posedge+1), hold until accepted
    task automatic send(input logic [DATA_W-1:0] x, input int e);
        int n;
        n = 0;
        x_in = x; in_valid = 1'b1; dir_exp = e;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; dir_exp = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] rand_x();
        int k, b;
        int bps[5] = '{256, 607, 608, 1279, 1280};
        k = $urandom % 8;
        if (k == 0) return 16'h8000;
        if (k == 1) return 16'h7FFF;
        if (k <= 3) begin
            b = bps[$urandom % 5] + int'($urandom % 3) - 1;
            if ($urandom % 2) b = -b;
            return DATA_W'(b);
        end
        return DATA_W'($urandom);
    endfunction

    initial begin
        int n;
        int dx[10] = '{16'h0000, 16'h0100, 16'hFF00, 607, 608, 1279, 1280,
                       16'hFB00, 16'h7FFF, 16'h8000};
        int dy[10] = '{128, 192, 64, 235, 235, 255, 256, 0, 256, 0};

        // Reset state while held
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_y_out", int'(y_out), 0);
        check("reset_in_ready", int'(in_ready), 1);
        #2 rst_n = 1'b1;
        idle(1);

        // Directed single samples with idle gaps
        for (int i = 0; i < 10; i++) begin
            send(DATA_W'(dx[i]), dy[i]);
            idle(4);
        end

        // Eight back-to-back inputs with a four-cycle stall mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++) send(rand_x(), -1);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(6);

        // Random traffic with random bubbles and backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            x_in      = rand_x();
            out_ready = ($urandom % 4) != 0;
            idle(1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        idle(6);

        // Asynchronous reset with three samples stalled in flight
        out_ready = 1'b0;
        send(16'h0100, -1);
        send(16'hFF00, -1);
        send(16'h0500, -1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_y_out", int'(y_out), 0);
        check("midreset_in_ready", int'(in_ready), 1);
        exp_q.delete(); stamp_q.delete(); stall_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        idle(1);
        out_ready = 1'b1;
        send(16'h0260, 235);
        idle(6);

`ifdef SIGMOID_SAT_COUNT_EN
        sat_clr = 1'b1; idle(1); sat_clr = 1'b0;
        send(16'h0500, -1);
        send(16'h0064, -1);
        send(16'hF830, -1);
        send(16'hFED4, -1);
        send(16'h7FFF, -1);
        idle(1);
        check("sat_cnt_count", int'(sat_cnt), 3);
        sat_clr = 1'b1;
        send(16'h7FFF, -1);
        sat_clr = 1'b0;
        check("sat_cnt_clear_wins", int'(sat_cnt), 0);
        idle(6);
`endif

        // Drain and confirm nothing was lost
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            n++;
            idle(1);
        end
        check("drain_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
